wb_axil_bridge: RTL and testbench
=================================

Name: wb_axil_bridge

Overview:
Standalone, parametrised Wishbone-target to AXI4-Lite-master bridge. It replaces the inline single-state-machine converters currently built into each converter wrapper. It adds four things: registered request capture, a bus timeout with safe drain of abandoned transactions, configurable error mapping, and error statistics. It sits between the Wishbone interconnect and any AXI4-Lite control port (RF data converter, clocking IP).

Parameters:
ADDR_W, 18, Wishbone/AXI address width (byte address, passed through unmodified).
DATA_W, 32, data width; must be 32 or 64.
TIMEOUT, 1024, cycles allowed from request issue to response; 0 disables the timeout.
ERR_ON_RESP, 1, 1: SLVERR/DECERR completes the WB cycle with wb_err_o; 0: completes with wb_ack_o and reports only via bridge_err_o.
CNT_W, 8, width of the saturating error counter.

Ports:
aclk  in  1  bridge clock (WB and AXI side share it)
aresetn  in  1  asynchronous active-low reset
wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  WB cycle/strobe/write
wb_adr_i  in  ADDR_W  WB address
wb_dat_i  in  DATA_W  WB write data
wb_sel_i  in  DATA_W/8  WB byte selects
wb_dat_o  out  DATA_W  WB read data
wb_ack_o, wb_err_o, wb_rty_o  out  1 each  WB termination (wb_rty_o tied 0)
m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready  AXI4-Lite write channels (master side)
m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready  AXI4-Lite read channels (master side)
bridge_err_o  out  1  one-cycle pulse on any error response or timeout
timeout_o  out  1  one-cycle pulse on timeout
err_count_o  out  CNT_W  saturating count of errors plus timeouts
err_addr_o  out  ADDR_W  address of the most recent erroring transaction

Behaviour:
- Reset (async assert, sync release): state IDLE; all valid/ready, wb_ack_o, wb_err_o, bridge_err_o and timeout_o are 0; wb_dat_o, err_count_o and err_addr_o are 0.
- States: IDLE, ISSUE, RESP, DONE, DRAIN.
- IDLE: when cyc&stb, latch adr/dat/sel/we into registers and go to ISSUE. All AXI address/data outputs come from these registers.
- ISSUE:
  - Write: awvalid and wvalid are asserted independently; each drops after its own handshake. Both handshakes done -> RESP.
  - Read: arvalid is asserted until arready -> RESP.
- RESP:
  - bready (write) or rready (read) is held high.
  - On bvalid or rvalid: capture resp and rdata into registers; go to DONE.
- DONE (one cycle): wb_ack_o or wb_err_o is asserted for exactly one cycle, then IDLE.
  - wb_dat_o holds the captured rdata from DONE until the next read capture.
  - Writes leave wb_dat_o unchanged.
- Error handling: resp[1]=1 pulses bridge_err_o in DONE, increments err_count_o (saturating at all-ones) and loads err_addr_o.
  - ERR_ON_RESP=1: the cycle terminates with wb_err_o instead of wb_ack_o.
  - ERR_ON_RESP=0: the cycle terminates with wb_ack_o.
- Timeout: the counter clears on IDLE->ISSUE and increments in ISSUE and RESP.
  - Reaching TIMEOUT: wb_err_o, bridge_err_o and timeout_o pulse one cycle; err_count_o/err_addr_o update; go to DRAIN.
  - This applies regardless of ERR_ON_RESP.
- DRAIN:
  - Any valid not yet handshaken stays asserted (AXI rule: valid never withdrawn).
  - bready/rready are held high.
  - The late response is discarded: no WB termination, no counter update.
  - On completion -> IDLE.
  - A WB request arriving during DRAIN is not latched; it is serviced from IDLE afterward.
- Latency with a zero-wait slave: stb seen at cycle 0, valids at cycle 1, bready/rready from cycle 2, response at cycle 2, ack at cycle 3.
- Handshake/response coincidences:
  - Simultaneous aw and w handshakes in the same cycle are legal.
  - bvalid arriving in the same cycle as the last handshake is not sampled until RESP.
- Timeout that fires on the same cycle a response arrives: the response wins (normal DONE), no timeout.
- wb_cyc_i dropping mid-transaction: the AXI transaction still completes internally; the WB termination is still pulsed. The master ignores it per WB rules.
- Reset mid-transaction: immediate return to IDLE with all valids deasserted. System reset must also reset the slave.

Test Plan:
- Zero-wait slave, write adr 0x00100, dat 0xDEADBEEF, sel 0xF -> awaddr=0x00100, wdata=0xDEADBEEF, wstrb=0xF; wb_ack_o high at cycle 3 only; err_count_o=0.
- Read with rvalid delayed 5 cycles, rdata 0x12345678 -> wb_ack_o once; wb_dat_o=0x12345678 holds after ack; rready high only in RESP.
- awready delayed 4 cycles, wready immediate -> wvalid lasts 1 cycle, awvalid 5 cycles, a single transaction, then ack.
- Error responses:
  - ERR_ON_RESP=1, bresp=2'b10 at adr 0x200 -> wb_err_o pulse, no ack, bridge_err_o pulse, err_count_o=1, err_addr_o=0x200.
  - ERR_ON_RESP=0 -> ack plus bridge_err_o.
- TIMEOUT=16, slave never asserts arready -> wb_err_o and timeout_o at 16 cycles, arvalid stays high.
  - Slave later answers -> no second termination; a new WB request issues only after drain.
- err_count_o saturation with CNT_W=2 after 5 errors -> 3.
- aresetn asserted during RESP -> all valid/ready drop asynchronously; state IDLE; counters 0.

Source files
------------

// File: rtl/wb_axil_bridge.sv
// Wishbone target to AXI4-Lite master bridge with registered request capture,
// bus timeout with safe drain of abandoned transactions, and error statistics.
module wb_axil_bridge #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 1024,
    parameter int ERR_ON_RESP = 1,
    parameter int CNT_W       = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_W-1:0]     wb_adr_i,
    input  logic [DATA_W-1:0]     wb_dat_i,
    input  logic [DATA_W/8-1:0]   wb_sel_i,
    output logic [DATA_W-1:0]     wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  bridge_err_o,
    output logic                  timeout_o,
    output logic [CNT_W-1:0]      err_count_o,
    output logic [ADDR_W-1:0]     err_addr_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {IDLE, ISSUE, RESP, DONE, DRAIN} state_t;

    state_t              state;
    logic                we_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   dat_q;
    logic [DATA_W/8-1:0] sel_q;
    logic [TW-1:0]       tcnt;

    logic       aw_ok, w_ok, resp_hs, tmo_hit, fire, log_err;
    logic [1:0] resp_code;

    assign m_axi_awaddr = adr_q;
    assign m_axi_araddr = adr_q;
    assign m_axi_wdata  = dat_q;
    assign m_axi_wstrb  = sel_q;
    assign wb_rty_o     = 1'b0;

    // A channel counts as complete once its valid has dropped or is handshaking now.
    assign aw_ok     = !m_axi_awvalid || m_axi_awready;
    assign w_ok      = !m_axi_wvalid || m_axi_wready;
    assign resp_hs   = we_q ? (m_axi_bvalid && m_axi_bready) : (m_axi_rvalid && m_axi_rready);
    assign resp_code = we_q ? m_axi_bresp : m_axi_rresp;
    assign tmo_hit   = (TIMEOUT != 0) && (tcnt == TO_LAST);
    // A response landing on the timeout cycle takes priority over the timeout.
    assign fire      = tmo_hit && ((state == ISSUE) || ((state == RESP) && !resp_hs));
    assign log_err   = fire || ((state == RESP) && resp_hs && resp_code[1]);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            adr_q         <= '0;
            dat_q         <= '0;
            sel_q         <= '0;
            tcnt          <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_rready  <= 1'b0;
            wb_dat_o      <= '0;
            wb_ack_o      <= 1'b0;
            wb_err_o      <= 1'b0;
            bridge_err_o  <= 1'b0;
            timeout_o     <= 1'b0;
            err_count_o   <= '0;
            err_addr_o    <= '0;
        end else begin
            wb_ack_o     <= 1'b0;
            wb_err_o     <= 1'b0;
            bridge_err_o <= 1'b0;
            timeout_o    <= 1'b0;

            case (state)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        we_q          <= wb_we_i;
                        adr_q         <= wb_adr_i;
                        dat_q         <= wb_dat_i;
                        sel_q         <= wb_sel_i;
                        tcnt          <= '0;
                        m_axi_awvalid <= wb_we_i;
                        m_axi_wvalid  <= wb_we_i;
                        m_axi_arvalid <= !wb_we_i;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    tcnt <= tcnt + 1'b1;
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if (m_axi_arready) m_axi_arvalid <= 1'b0;
                    if (fire || (we_q ? (aw_ok && w_ok) : m_axi_arready)) begin
                        m_axi_bready <= we_q;
                        m_axi_rready <= !we_q;
                        state        <= fire ? DRAIN : RESP;
                    end
                end
                RESP: begin
                    tcnt <= tcnt + 1'b1;
                    if (resp_hs) begin
                        m_axi_bready <= 1'b0;
                        m_axi_rready <= 1'b0;
                        if (!we_q) wb_dat_o <= m_axi_rdata;
                        if (resp_code[1] && (ERR_ON_RESP != 0)) wb_err_o <= 1'b1;
                        else                                    wb_ack_o <= 1'b1;
                        state <= DONE;
                    end else if (fire) begin
                        state <= DRAIN;
                    end
                end
                DONE: state <= IDLE;
                DRAIN: begin
                    // Outstanding valids stay up until accepted; the late response is dropped.
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if (m_axi_arready) m_axi_arvalid <= 1'b0;
                    if (resp_hs) begin
                        m_axi_bready <= 1'b0;
                        m_axi_rready <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (fire) begin
                wb_err_o  <= 1'b1;
                timeout_o <= 1'b1;
            end
            if (log_err) begin
                bridge_err_o <= 1'b1;
                err_addr_o   <= adr_q;
                if (err_count_o != '1) err_count_o <= err_count_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_axil_bridge.sv
// Scoreboard bench for wb_axil_bridge: two instances (ERR_ON_RESP=1 and 0) share
// one Wishbone master and one AXI4-Lite slave model.
module tb_wb_axil_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [17:0] wb_adr = '0;
    logic [31:0] wb_dat_w = '0;
    logic [3:0]  wb_sel = '0;

    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, bvalid = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    logic [31:0] dat1, dat0, wdata, wdata0;
    logic        ack1, err1, rty1, ack0, err0, rty0;
    logic [17:0] awaddr, araddr, awaddr0, araddr0, eaddr1, eaddr0;
    logic [3:0]  wstrb, wstrb0;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awvalid0, wvalid0, bready0, arvalid0, rready0;
    logic        berr1, tmo1, berr0, tmo0;
    logic [1:0]  cnt1, cnt0;

    wb_axil_bridge #(.ADDR_W(18), .DATA_W(32), .TIMEOUT(16), .ERR_ON_RESP(1), .CNT_W(2)) dut1 (
        .aclk(clk), .aresetn(rst_n),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_adr_i(wb_adr),
        .wb_dat_i(wb_dat_w), .wb_sel_i(wb_sel), .wb_dat_o(dat1),
        .wb_ack_o(ack1), .wb_err_o(err1), .wb_rty_o(rty1),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .bridge_err_o(berr1), .timeout_o(tmo1), .err_count_o(cnt1), .err_addr_o(eaddr1)
    );

    wb_axil_bridge #(.ADDR_W(18), .DATA_W(32), .TIMEOUT(16), .ERR_ON_RESP(0), .CNT_W(2)) dut0 (
        .aclk(clk), .aresetn(rst_n),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_adr_i(wb_adr),
        .wb_dat_i(wb_dat_w), .wb_sel_i(wb_sel), .wb_dat_o(dat0),
        .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0),
        .m_axi_awaddr(awaddr0), .m_axi_awvalid(awvalid0), .m_axi_awready(awready),
        .m_axi_wdata(wdata0), .m_axi_wstrb(wstrb0), .m_axi_wvalid(wvalid0), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready0),
        .m_axi_araddr(araddr0), .m_axi_arvalid(arvalid0), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready0),
        .bridge_err_o(berr0), .timeout_o(tmo0), .err_count_o(cnt0), .err_addr_o(eaddr0)
    );

    typedef struct {
        bit          we;
        logic [17:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        bit          e1_err;
        bit          e0_err;
        bit          berr;
        bit          tmo;
        bit          chk_dat;
        logic [31:0] dat;
        logic [1:0]  cnt;
        logic [17:0] eaddr;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc_cnt = 0;
    int   aw_hi = 0, w_hi = 0, rr_hi = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // AXI4-Lite slave model: per-channel ready delays and response delays,
    // driven on the falling edge so the bridge samples stable inputs.
    int   aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    bit   aw_took = 0, w_took = 0, ar_took = 0, b_took = 0, r_took = 0;
    bit   aw_done = 0, w_done = 0, ar_done = 0;
    logic [17:0] got_awaddr = '0;
    logic [31:0] got_wdata = '0;
    logic [3:0]  got_wstrb = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_took = 0; w_took = 0; ar_took = 0; b_took = 0; r_took = 0;
                aw_done = 0; w_done = 0; ar_done = 0;
            end else begin
                if (aw_took) aw_done = 1;
                if (w_took)  w_done = 1;
                if (ar_took) ar_done = 1;
                if (b_took) begin bvalid = 0; aw_done = 0; w_done = 0; b_cnt = 0; end
                if (r_took) begin rvalid = 0; ar_done = 0; r_cnt = 0; end
                if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
                else begin awready = 0; aw_cnt = 0; end
                if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
                else begin wready = 0; w_cnt = 0; end
                if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end
                else begin arready = 0; ar_cnt = 0; end
                aw_took = awvalid && awready;
                w_took  = wvalid && wready;
                ar_took = arvalid && arready;
                if (aw_took) got_awaddr = awaddr;
                if (w_took) begin got_wdata = wdata; got_wstrb = wstrb; end
                if (aw_done && w_done && !bvalid) begin
                    if (b_cnt >= b_dly) bvalid = 1; else b_cnt++;
                end
                if (ar_done && !rvalid) begin
                    if (r_cnt >= r_dly) rvalid = 1; else r_cnt++;
                end
                b_took = bvalid && bready;
                r_took = rvalid && rready;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            aw_hi = aw_hi + (awvalid ? 1 : 0);
            w_hi  = w_hi + (wvalid ? 1 : 0);
            rr_hi = rr_hi + (rready ? 1 : 0);
        end
    end

    // Monitor: every Wishbone termination is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ack1 || err1) begin
                    if (sb.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_term: got ack=%0b err=%0b required no termination", ack1, err1);
                    end else begin
                        e = sb.pop_front();
                        chk("term_kind_eor1", {err1, ack1}, e.e1_err ? 2'b10 : 2'b01);
                        chk("term_kind_eor0", {err0, ack0}, e.e0_err ? 2'b10 : 2'b01);
                        chk("rty_tied", {rty1, rty0}, 2'b00);
                        chk("bridge_err", {berr1, berr0}, {e.berr, e.berr});
                        chk("timeout_pulse", {tmo1, tmo0}, {e.tmo, e.tmo});
                        chk("err_count", {cnt1, cnt0}, {e.cnt, e.cnt});
                        chk("err_addr1", eaddr1, e.eaddr);
                        chk("err_addr0", eaddr0, e.eaddr);
                        chk("axi_addr1", e.we ? awaddr : araddr, e.adr);
                        chk("axi_addr0", e.we ? awaddr0 : araddr0, e.adr);
                        if (e.we) begin
                            chk("axi_wdata", {wdata, wdata0}, {e.wdat, e.wdat});
                            chk("axi_wstrb", {wstrb, wstrb0}, {e.sel, e.sel});
                        end
                        if (e.chk_dat) chk("rdata", {dat1, dat0}, {e.dat, e.dat});
                        if (e.lat != 0) chk("latency", cyc_cnt - e.t0, e.lat);
                    end
                end else if (ack0 || err0 || berr1 || berr0 || tmo1 || tmo0) begin
                    n_checks++; n_fail++;
                    $display("FAIL stray_pulse: got ack0=%0b err0=%0b berr=%0b%0b tmo=%0b%0b required none",
                             ack0, err0, berr1, berr0, tmo1, tmo0);
                end
            end
        end
    end

    task automatic start_req(input bit we, input logic [17:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input bit e1_err, input bit e0_err,
                             input bit berr, input bit tmo, input bit chk_dat,
                             input logic [31:0] edat, input logic [1:0] ecnt,
                             input logic [17:0] eaddr, input int lat);
        exp_t e;
        @(negedge clk);
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
        e.we = we; e.adr = adr; e.wdat = dat; e.sel = sel; e.e1_err = e1_err; e.e0_err = e0_err;
        e.berr = berr; e.tmo = tmo; e.chk_dat = chk_dat; e.dat = edat; e.cnt = ecnt;
        e.eaddr = eaddr; e.lat = lat; e.t0 = cyc_cnt;
        sb.push_back(e);
    endtask

    task automatic wait_term(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack1 || err1) begin seen = 1; break; end
        end
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        chk("term_seen", seen, 1'b1);
    endtask

    task automatic wb_xfer(input bit we, input logic [17:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input bit e1_err, input bit e0_err,
                           input bit berr, input bit tmo, input bit chk_dat,
                           input logic [31:0] edat, input logic [1:0] ecnt,
                           input logic [17:0] eaddr, input int lat);
        start_req(we, adr, dat, sel, e1_err, e0_err, berr, tmo, chk_dat, edat, ecnt, eaddr, lat);
        wait_term(100);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
        chk("reset_wb", {ack1, err1, berr1, tmo1, ack0, err0}, 6'b0);
        chk("reset_regs", {dat1, cnt1, eaddr1}, '0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // Zero-wait write; aw and w handshake together, ack 3 cycles after stb.
        aw_hi = 0; w_hi = 0;
        wb_xfer(1, 18'h00100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2'd0, 18'h0, 3);
        chk("hs_awaddr", got_awaddr, 18'h00100);
        chk("hs_wdata", got_wdata, 32'hDEADBEEF);
        chk("hs_wstrb", got_wstrb, 4'hF);
        chk("zw_valid_cycles", {aw_hi[7:0], w_hi[7:0]}, {8'd1, 8'd1});

        // Read with rvalid 5 cycles late: RESP spans cycles 2..7, ack at 8.
        r_dly = 5; rdata = 32'h12345678; rr_hi = 0;
        wb_xfer(0, 18'h00104, 32'h0, 4'hF, 0, 0, 0, 0, 1, 32'h12345678, 2'd0, 18'h0, 8);
        chk("rready_cycles", rr_hi, 6);
        repeat (3) @(negedge clk);
        chk("rdata_hold", dat1, 32'h12345678);
        r_dly = 0;

        // awready 4 cycles late, wready immediate.
        aw_dly = 4; aw_hi = 0; w_hi = 0;
        wb_xfer(1, 18'h00108, 32'h0BADF00D, 4'h5, 0, 0, 0, 0, 0, 0, 2'd0, 18'h0, 7);
        chk("aw_valid_cycles", aw_hi, 5);
        chk("w_valid_cycles", w_hi, 1);
        chk("write_keeps_rdata", dat1, 32'h12345678);
        aw_dly = 0;

        // SLVERR on write: err on ERR_ON_RESP=1, ack on ERR_ON_RESP=0.
        bresp = 2'b10;
        wb_xfer(1, 18'h00200, 32'h1, 4'h1, 1, 0, 1, 0, 0, 0, 2'd1, 18'h00200, 3);
        bresp = 2'b00;

        // Slave never accepts the read address: timeout 16 cycles after issue.
        ar_dly = 1000;
        wb_xfer(0, 18'h00300, 32'h0, 4'hF, 1, 1, 1, 1, 0, 0, 2'd2, 18'h00300, 17);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_arvalid", arvalid, 1'b1);
        end
        // New write during drain must wait until the late response is absorbed.
        start_req(1, 18'h00040, 32'hCAFEF00D, 4'h3, 0, 0, 0, 0, 0, 0, 2'd2, 18'h00300, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("drain_no_issue", {awvalid, arvalid}, 2'b01);
        end
        @(posedge clk);
        #1 ar_dly = 0;
        wait_term(50);
        @(negedge clk);

        // EXOKAY is not an error; DECERR and SLVERR are, counter saturates at 3.
        rresp = 2'b01; rdata = 32'h0000A5A5;
        wb_xfer(0, 18'h00404, 32'h0, 4'hF, 0, 0, 0, 0, 1, 32'h0000A5A5, 2'd2, 18'h00300, 3);
        rresp = 2'b11; rdata = 32'hBAD0BAD0;
        wb_xfer(0, 18'h00408, 32'h0, 4'hF, 1, 0, 1, 0, 1, 32'hBAD0BAD0, 2'd3, 18'h00408, 3);
        bresp = 2'b10;
        wb_xfer(1, 18'h0040C, 32'h2, 4'h2, 1, 0, 1, 0, 0, 0, 2'd3, 18'h0040C, 3);
        bresp = 2'b00; rresp = 2'b10; rdata = 32'h11112222;
        wb_xfer(0, 18'h00410, 32'h0, 4'hF, 1, 0, 1, 0, 1, 32'h11112222, 2'd3, 18'h00410, 3);
        rresp = 2'b00;

        // Reset while waiting in RESP.
        r_dly = 10;
        @(negedge clk);
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 18'h00500; wb_sel = 4'hF;
        begin
            bit in_resp = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (rready) begin in_resp = 1; break; end
            end
            chk("reached_resp", in_resp, 1'b1);
        end
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_valids1", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
        chk("rst_valids0", {awvalid0, wvalid0, arvalid0, bready0, rready0}, 5'b0);
        chk("rst_counts", {cnt1, cnt0}, 4'b0);
        chk("rst_regs", {dat1, eaddr1, eaddr0}, '0);
        wb_cyc = 0; wb_stb = 0;
        sb.delete();
        r_dly = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);

        wb_xfer(1, 18'h00010, 32'h55AA55AA, 4'hC, 0, 0, 0, 0, 0, 0, 2'd0, 18'h0, 3);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
